latch_monitor: RTL

LATCH_MONITOR -- requirements
Module: latch_monitor

---
 rtl/latch_monitor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/latch_monitor.sv
// latch_monitor: watches a D-latch (d, e in; q, p out) and checks its outputs
// against an internally tracked expected value once its inputs have settled.
// Mismatches are counted and set a sticky error flag. Sampled enable cycles
// are counted too.
module latch_monitor #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1    // clean cycles before checking; 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             e,
    input  logic             q,
    input  logic             p,
    input  logic             clr,
    output logic [1:0]       state,
    output logic             chk_valid,
    output logic             err,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [CNT_W-1:0] load_cnt
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_ERROR  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_settle_cnt;
    logic [3:0]       w_settle_next;
    logic             r_d_prev;
    logic             r_e_prev;
    logic             r_exp_q;
    logic             r_exp_valid;
    logic             r_err;
    logic             r_chk_valid;
    logic [CNT_W-1:0] r_mism_cnt;
    logic [CNT_W-1:0] r_load_cnt;

    logic             w_change;
    logic             w_pass;
    logic             w_compare;
    logic             w_fail;
    logic [4:0]       w_settle_inc;
    state_t           w_resume;

    // Input change detect, pass criterion (p must be the complement of q)
    // and where a settled FSM goes back to (ERROR is sticky).
    assign w_change     = (d != r_d_prev) || (e != r_e_prev);
    assign w_pass       = (q == r_exp_q) && (p != q);
    assign w_settle_inc = {1'b0, r_settle_cnt} + 5'd1;
    assign w_resume     = r_err ? ST_ERROR : ST_CHECK;
    assign w_fail       = w_compare && !w_pass;

    // Next-state, settle counter and compare-enable; clr forces INIT.
    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle_cnt;
        w_compare     = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (e) begin
                    w_state_next  = ST_SETTLE;
                    w_settle_next = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (w_change) begin
                    w_settle_next = 4'd0;
                end else if (w_settle_inc >= 5'(SETTLE)) begin
                    w_state_next  = w_resume;
                    w_settle_next = 4'd0;
                end else begin
                    w_settle_next = w_settle_inc[3:0];
                end
            end
            ST_CHECK, ST_ERROR: begin
                if (w_change) begin
                    w_state_next  = ST_SETTLE;
                    w_settle_next = 4'd0;
                end else if (r_exp_valid) begin
                    w_compare = 1'b1;
                    if (!w_pass) begin
                        w_state_next = ST_ERROR;
                    end
                end
            end
            default: w_state_next = ST_INIT;
        endcase
        if (clr) begin
            w_state_next  = ST_INIT;
            w_settle_next = 4'd0;
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_settle_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
        end
    end

    // Input history, expected value, sticky error and saturating counters;
    // clr wins over any mismatch or load in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_prev    <= 1'b0;
            r_e_prev    <= 1'b0;
            r_exp_q     <= 1'b0;
            r_exp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_chk_valid <= 1'b0;
            r_mism_cnt  <= '0;
            r_load_cnt  <= '0;
        end else begin
            r_d_prev <= d;
            r_e_prev <= e;
            if (clr) begin
                r_exp_valid <= 1'b0;
                r_err       <= 1'b0;
                r_chk_valid <= 1'b0;
                r_mism_cnt  <= '0;
                r_load_cnt  <= '0;
            end else begin
                if (e) begin
                    r_exp_q     <= d;
                    r_exp_valid <= 1'b1;
                    if (r_load_cnt != CNT_MAX) begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
                r_chk_valid <= w_compare;
                if (w_fail) begin
                    r_err <= 1'b1;
                    if (r_mism_cnt != CNT_MAX) begin
                        r_mism_cnt <= r_mism_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign state     = r_state;
    assign chk_valid = r_chk_valid;
    assign err       = r_err;
    assign mism_cnt  = r_mism_cnt;
    assign load_cnt  = r_load_cnt;

endmodule
